// File: rtl/fsm_pkg.sv
// Shared types and constants for the parking-lot FSM design.
// The debounce state encoding and the input channel map live here.
package fsm_pkg;

   // Per-channel debounce states: stable low, qualifying high, stable high, qualifying low
   typedef enum logic [1:0] {ST_LOW, WAIT_HIGH, ST_HIGH, WAIT_LOW} db_state_t;

   // Bit positions of the physical inputs within btn_raw
   localparam int CH_TICKET = 0;
   localparam int CH_COIN   = 1;
   localparam int CH_CAR    = 2;

endpackage

// File: rtl/btn_debounce_ch.sv
// Single-channel conditioner: 2-flop synchroniser, debounce FSM with a
// stability counter, and registered level / rise / fall outputs.
module btn_debounce_ch
   import fsm_pkg::*;
#(
   parameter int DB_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic R,
   input  logic raw,
   output logic level,
   output logic rise,
   output logic fall
);

   // Counter only ever reaches DB_CYCLES-1, so $clog2 bits are enough
   localparam int            CW       = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic          s1_reg;
   logic          s2_reg;
   db_state_t     state_reg;
   logic [CW-1:0] cnt_reg;
   logic          level_reg;
   logic          rise_reg;
   logic          fall_reg;

   // Bring the asynchronous pad into the clock domain
   always_ff @(posedge clk or negedge R) begin
      if (!R) begin
         s1_reg <= 1'b0;
         s2_reg <= 1'b0;
      end else begin
         s1_reg <= raw;
         s2_reg <= s1_reg;
      end
   end

   // Debounce FSM; outputs are registered alongside the state so nothing is combinational from raw
   always_ff @(posedge clk or negedge R) begin
      if (!R) begin
         state_reg <= ST_LOW;
         cnt_reg   <= '0;
         level_reg <= 1'b0;
         rise_reg  <= 1'b0;
         fall_reg  <= 1'b0;
      end else begin
         rise_reg <= 1'b0;
         fall_reg <= 1'b0;
         case (state_reg)
            ST_LOW: begin
               if (s2_reg) begin
                  state_reg <= WAIT_HIGH;
                  cnt_reg   <= CNT_ONE;
               end else begin
                  cnt_reg <= '0;
               end
            end
            WAIT_HIGH: begin
               if (!s2_reg) begin
                  // bounce: drop back without touching the level
                  state_reg <= ST_LOW;
                  cnt_reg   <= '0;
               end else if (cnt_reg == CNT_LAST) begin
                  state_reg <= ST_HIGH;
                  cnt_reg   <= '0;
                  level_reg <= 1'b1;
                  rise_reg  <= 1'b1;
               end else begin
                  cnt_reg <= cnt_reg + CNT_ONE;
               end
            end
            ST_HIGH: begin
               if (!s2_reg) begin
                  state_reg <= WAIT_LOW;
                  cnt_reg   <= CNT_ONE;
               end else begin
                  cnt_reg <= '0;
               end
            end
            WAIT_LOW: begin
               if (s2_reg) begin
                  state_reg <= ST_HIGH;
                  cnt_reg   <= '0;
               end else if (cnt_reg == CNT_LAST) begin
                  state_reg <= ST_LOW;
                  cnt_reg   <= '0;
                  level_reg <= 1'b0;
                  fall_reg  <= 1'b1;
               end else begin
                  cnt_reg <= cnt_reg + CNT_ONE;
               end
            end
            default: begin
               state_reg <= ST_LOW;
               cnt_reg   <= '0;
            end
         endcase
      end
   end

   assign level = level_reg;
   assign rise  = rise_reg;
   assign fall  = fall_reg;

endmodule

// File: rtl/btn_conditioner.sv
// Input front end: one independent synchronise-and-debounce channel per
// raw button/switch (ticket, coin, car-presence).
module btn_conditioner
   import fsm_pkg::*;
#(
   parameter int N_CH      = 3,
   parameter int DB_CYCLES = 1_000_000
) (
   input  logic            clk,
   input  logic            R,
   input  logic [N_CH-1:0] btn_raw,
   output logic [N_CH-1:0] btn_level,
   output logic [N_CH-1:0] btn_rise,
   output logic [N_CH-1:0] btn_fall
);

   // One debounce channel per input bit
   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
         btn_debounce_ch #(
            .DB_CYCLES(DB_CYCLES)
         ) u_ch (
            .clk  (clk),
            .R    (R),
            .raw  (btn_raw[gi]),
            .level(btn_level[gi]),
            .rise (btn_rise[gi]),
            .fall (btn_fall[gi])
         );
      end
   endgenerate

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DB_CYCLES=4: each step pushes the
// expected per-cycle outputs into a scoreboard queue, which is then drained
// one entry per clock against the DUT.
module tb_btn_conditioner;

   localparam int N_CH      = 3;
   localparam int DB_CYCLES = 4;
   // Edges from a raw change until the level/pulse appear
   localparam int LAT       = DB_CYCLES + 2;

   logic            clk;
   logic            R;
   logic [N_CH-1:0] btn_raw;
   logic [N_CH-1:0] btn_level;
   logic [N_CH-1:0] btn_rise;
   logic [N_CH-1:0] btn_fall;

   typedef struct {
      string           tag;
      logic [N_CH-1:0] lvl;
      logic [N_CH-1:0] rise;
      logic [N_CH-1:0] fall;
   } exp_t;

   exp_t sb[$];
   int   vectors     = 0;
   int   miscompares = 0;

   btn_conditioner #(
      .N_CH     (N_CH),
      .DB_CYCLES(DB_CYCLES)
   ) dut (
      .clk      (clk),
      .R        (R),
      .btn_raw  (btn_raw),
      .btn_level(btn_level),
      .btn_rise (btn_rise),
      .btn_fall (btn_fall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic push(input string tag, input int n,
                       input logic [N_CH-1:0] l, input logic [N_CH-1:0] r, input logic [N_CH-1:0] f);
      exp_t e;
      e.tag  = tag;
      e.lvl  = l;
      e.rise = r;
      e.fall = f;
      repeat (n) sb.push_back(e);
   endtask

   // Expected timeline for one raw change: old level for LAT-1 edges,
   // new level with pulses on edge LAT, then two quiet cycles
   task automatic settle(input string tag, input logic [N_CH-1:0] old_l, input logic [N_CH-1:0] new_l,
                         input logic [N_CH-1:0] r, input logic [N_CH-1:0] f);
      push({tag, "_wait"},  LAT - 1, old_l, '0, '0);
      push({tag, "_edge"},  1,       new_l, r,  f);
      push({tag, "_after"}, 2,       new_l, '0, '0);
   endtask

   task automatic compare_one();
      exp_t e;
      e = sb.pop_front();
      vectors++;
      assert ({btn_level, btn_rise, btn_fall} === {e.lvl, e.rise, e.fall})
      else begin
         miscompares++;
         $error("FAIL %s: got level=%b rise=%b fall=%b, expected level=%b rise=%b fall=%b",
                e.tag, btn_level, btn_rise, btn_fall, e.lvl, e.rise, e.fall);
      end
   endtask

   task automatic drain();
      while (sb.size() > 0) begin
         @(posedge clk);
         #1;
         compare_one();
      end
   endtask

   task automatic drive(input logic [N_CH-1:0] v);
      @(negedge clk);
      btn_raw = v;
   endtask

   initial begin
      R       = 1'b0;
      btn_raw = 3'b111;

      // 1. Reset holds everything at 0 even with all inputs high
      push("reset_hold", 5, 3'b000, 3'b000, 3'b000);
      drain();
      @(negedge clk);
      R = 1'b1;
      settle("reset_release", 3'b000, 3'b111, 3'b111, 3'b000);
      drain();

      // Bring all channels low again
      drive(3'b000);
      settle("all_low", 3'b111, 3'b000, 3'b000, 3'b111);
      drain();

      // 2. Clean press on ticket channel
      drive(3'b001);
      settle("press_ch0", 3'b000, 3'b001, 3'b001, 3'b000);
      drain();

      // 3. Coin channel bounces 1,0,1,0 every 2 cycles, then holds high
      for (int k = 0; k < 4; k++) begin
         drive((k % 2 == 0) ? 3'b011 : 3'b001);
         push("bounce_ch1", 1, 3'b001, 3'b000, 3'b000);
         drain();
         push("bounce_ch1", 1, 3'b001, 3'b000, 3'b000);
         drain();
      end
      drive(3'b011);
      settle("bounce_hold_ch1", 3'b001, 3'b011, 3'b010, 3'b000);
      drain();

      // 4. Release of ticket channel
      drive(3'b010);
      settle("release_ch0", 3'b011, 3'b010, 3'b000, 3'b001);
      drain();

      // 5. Car channel goes high, then ch0 rises while ch2 falls on the same cycle
      drive(3'b110);
      settle("car_on", 3'b010, 3'b110, 3'b100, 3'b000);
      drain();
      drive(3'b011);
      settle("simul_ch0_ch2", 3'b110, 3'b011, 3'b001, 3'b100);
      drain();

      // 6. Coin channel low, then high for a few cycles and reset mid-count
      drive(3'b001);
      settle("coin_low", 3'b011, 3'b001, 3'b000, 3'b010);
      drain();
      drive(3'b011);
      push("coin_counting", 4, 3'b001, 3'b000, 3'b000);
      drain();
      @(negedge clk);
      R = 1'b0;
      #1;
      push("async_clear", 1, 3'b000, 3'b000, 3'b000);
      compare_one();
      push("mid_reset", 1, 3'b000, 3'b000, 3'b000);
      drain();
      @(negedge clk);
      R = 1'b1;
      settle("after_mid_reset", 3'b000, 3'b011, 3'b011, 3'b000);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Front-end input stage of the parking-lot FSM design. Synchronises and debounces the raw Basys3 push-buttons and switches (ticket, coin, car-presence) before they reach the sealing machine and barrier machine. For every channel it outputs a clean level plus single-cycle rise and fall pulses. All channels share one clock and one asynchronous active-low reset.

## Interface
- `N_CH`, 3: number of independent input channels. Bit 0 is ticket (iT), bit 1 is coin (iM), bit 2 is car-presence (C).
- `DB_CYCLES`, 1_000_000: consecutive stable cycles required to accept a new level. This is 10 ms at 100 MHz. Legal range is ≥2.
- `clk`  in  1  system clock (100 MHz on Basys3).
- `R`  in  1  reset, asynchronous assert, active-low. `R`=0 resets the block.
- `btn_raw`  in  N_CH  raw asynchronous pad inputs.
- `btn_level`  out  N_CH  debounced level, registered.
- `btn_rise`  out  N_CH  one-cycle pulse when `btn_level` goes 0→1, registered.
- `btn_fall`  out  N_CH  one-cycle pulse when `btn_level` goes 1→0, registered.

## Operation
Per channel, all channels fully independent:
- **Synchroniser:** 2-flop synchroniser `s1`→`s2`, both reset to 0.
- **Counter:** `cnt`, width $clog2(DB_CYCLES), resets to 0.
- **FSM states:** `ST_LOW`, `WAIT_HIGH`, `ST_HIGH`, `WAIT_LOW`. Reset state is `ST_LOW`.
- **`ST_LOW`:**
  - `s2`=1 → go to `WAIT_HIGH` with `cnt`=1.
  - Otherwise stay, `cnt`=0.
- **`WAIT_HIGH`:**
  - `s2`=0 → return to `ST_LOW` with `cnt`=0. This is a bounce: no pulse, level unchanged.
  - `s2`=1 and `cnt`==DB_CYCLES-1 → go to `ST_HIGH` with `cnt`=0. Assert `btn_rise` for exactly that cycle.
  - Otherwise `cnt`++.
- **`ST_HIGH`** and **`WAIT_LOW`:** mirror images of the above. Exiting `WAIT_LOW` to `ST_LOW` asserts `btn_fall`.
- **Outputs:**
  - `btn_level` = 1 in `ST_HIGH` and `WAIT_LOW`, 0 otherwise.
  - Outputs are registered with the state, so there are no combinational paths from `btn_raw`.
- **Reset values:** `btn_level`, `btn_rise` and `btn_fall` are 0. All FSMs are in `ST_LOW` with `cnt`=0.
- **Reset mid-operation:** state is discarded immediately. No pulse is emitted on assertion or release. A button held through reset release produces a normal `btn_rise` after full debounce.
- **Pulse exclusivity:** `btn_rise` and `btn_fall` are never both high on the same channel in the same cycle. Each pulse is exactly 1 cycle wide. Separate pulses on one channel are at least DB_CYCLES cycles apart.
- **Counter width:** `cnt` never exceeds DB_CYCLES-1, so there is no wrap-around.

## Timing
- **Rise latency:** `btn_raw` goes high and stays high before capture edge 1. `btn_level` and `btn_rise` are high after edge DB_CYCLES+2.
  - Edges 1–2: synchroniser.
  - Edges 3..DB_CYCLES+2: counting.
- **Fall latency:** identical, DB_CYCLES+2 edges.
- **Bounce rejection:** a pulse on `btn_raw` shorter than DB_CYCLES cycles (as seen at `s2`) produces no output change.
- **Bounce restart:** a return-to-old-value during a WAIT state restarts the count from zero on the next qualifying edge.
- **Downstream usage:**
  - Downstream Moore/Mealy machines sample `btn_rise` on the same clock.
  - Coin and ticket events use the pulse outputs.
  - Car-presence uses `btn_level`.

## Structure
- **Shared package `fsm_pkg`:**
  - `typedef enum logic [1:0] {ST_LOW, WAIT_HIGH, ST_HIGH, WAIT_LOW} db_state_t`.
  - Channel index constants `CH_TICKET=0`, `CH_COIN=1`, `CH_CAR=2`.
- **Sub-module `btn_debounce_ch`:** single channel, holding the synchroniser, FSM, counter and registered outputs. Parameter `DB_CYCLES`.
- **Top level:** `btn_conditioner` instantiates N_CH copies via a generate loop.

## Test plan
All scenarios run with DB_CYCLES=4 and N_CH=3.
1. **Reset values:** hold `R`=0 for 5 cycles with `btn_raw`=3'b111, then release → all outputs 0 during reset. `btn_level`=3'b111 and `btn_rise`=3'b111 for one cycle at edge 6 after release. No `btn_fall` at any time.
2. **Clean press:** ch0 from 0 to 1 held high → `btn_level[0]`=1 and `btn_rise[0]`=1 after edge 6. `btn_rise[0]`=0 on edge 7. Other channels stay 0.
3. **Bounce rejection:** ch1 toggles 1,0,1,0 every 2 cycles, then holds 1 → no output during toggling. Single `btn_rise[1]` 6 edges after the final stable 1.
4. **Release:** ch0 from 1 to 0 after being debounced high → `btn_fall[0]` one cycle, `btn_level[0]`=0 at edge 6. `btn_rise[0]` stays 0.
5. **Simultaneous events:** ch0 rises while ch2 falls on the same cycle → `btn_rise[0]` and `btn_fall[2]` pulse on the same edge, independently.
6. **Reset mid-count:** ch1 has been high for 3 cycles (in `WAIT_HIGH`), then `R` pulses 0 for 1 cycle → no pulse. After release, `btn_rise[1]` occurs 6 edges later if ch1 stays high.
